tt_um_micro_descramble_rx: RTL and testbench
============================================

TT_UM_MICRO_DESCRAMBLE_RX -- requirements
Module: tt_um_micro_descramble_rx

Interface
REQ-001 Parameter SCRAMBLE_KEY, default 8'h55, the XOR key applied by the transmitting micro tile.
REQ-002 clk  input  1  the single clock; all state is updated on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 ui_in  input  8  [0] sdata serial bit; [1] sstrobe bit strobe; [2] frame (high = byte framing active); [3] view select (0 = data, 1 = status); [4] ack; [5] err_clr; [7:6] unused.
REQ-005 uo_out  output  8  registered; decoded byte when view=0, status word when view=1.

Function
REQ-006 sdata, sstrobe and frame each SHALL pass through a two-flop synchroniser; all further logic uses only the synchronised copies.
REQ-007 A bit event SHALL be the synchronised sstrobe rising edge: 1 in the 2nd sync stage, 0 in a 3rd history flop.
REQ-008 FSM states SHALL be IDLE and SHIFT.
REQ-009 IDLE -> SHIFT on a bit event with synchronised frame high; that bit is shifted in as bit 7 (MSB-first) and bit_cnt becomes 1.
REQ-010 In SHIFT, each bit event SHALL shift sdata into the LSB and increment a 3-bit bit_cnt.
REQ-011 On the 8th bit event: data_reg <= shifted byte XOR SCRAMBLE_KEY, valid <= 1, byte_cnt increments, bit_cnt <= 0; FSM stays in SHIFT.
REQ-012 Latency: a high sstrobe sampled at clock edge N for the 8th bit SHALL make the new byte visible on uo_out (view=0) after edge N+3.
REQ-013 Synchronised frame low in SHIFT with bit_cnt != 0: partial byte discarded, frame_err set (sticky), FSM -> IDLE.
REQ-014 Synchronised frame low in SHIFT with bit_cnt == 0: FSM -> IDLE, no error.
REQ-015 ack high for a cycle SHALL clear valid (level-sensitive, not synchronised).
REQ-016 Byte completion while valid == 1: overrun set (sticky); data_reg is overwritten with the new byte.
REQ-017 Simultaneous ack and byte completion: valid stays 1; overrun is not set.
REQ-018 err_clr high SHALL clear overrun and frame_err; if a set condition occurs in the same cycle, the set wins.
REQ-019 byte_cnt is 4 bits and wraps 15 -> 0.
REQ-020 Status word = {byte_cnt[3:0], valid, overrun, frame_err, busy}, with busy = (state == SHIFT).
REQ-021 uo_out SHALL be a register loaded every cycle from the selected view (one-cycle view latency).
REQ-022 ui_in[7:6] SHALL have no effect.

Reset
REQ-023 While rst is high, the following SHALL be 0 immediately, without waiting for a clock edge: uo_out, data_reg, shift register, bit_cnt, byte_cnt, valid, overrun, frame_err and all sync/history flops; FSM = IDLE.
REQ-024 Reset asserted mid-byte SHALL discard the partial byte; the first bit event after release with frame high starts a fresh byte.

Structure
REQ-025 Shared package tt_micro_rx_pkg SHALL hold the state typedef (IDLE, SHIFT), the default SCRAMBLE_KEY constant and the status bit-position constants.
REQ-026 One sub-module, tt_micro_sync2 (width-parameterised two-flop synchroniser with async active-high reset), SHALL be instantiated for {frame, sstrobe, sdata}.

Verification
REQ-027 Frame high; send scrambled byte 8'h00 (i.e. data 8'h55), MSB-first -> view=0 shows 8'h55 at edge N+3; status = 8'b0001_1001.
REQ-028 Two bytes without ack (data 8'hA5 then 8'h3C) -> data 8'h3C, overrun=1; then err_clr -> overrun=0, valid=1.
REQ-029 Frame dropped after 5 bits -> frame_err=1, busy=0, data_reg unchanged; the next full byte decodes correctly.
REQ-030 Ack in the same cycle as 8th-bit completion -> valid=1, overrun=0.
REQ-031 Send 17 bytes -> byte_cnt reads 1 (wrap).
REQ-032 rst pulsed mid-byte (after 3 bits) -> uo_out=0 asynchronously; the next 8 bits decode as a clean byte.

Source files
------------

// File: rtl/tt_micro_rx_pkg.sv
// Shared types and constants for the micro-tile serial descrambling receiver.
// Holds the FSM state type, the default XOR key and the status word bit map.
// Status word layout: {byte_cnt[3:0], valid, overrun, frame_err, busy}.
package tt_micro_rx_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [7:0] DEFAULT_SCRAMBLE_KEY = 8'h55;

  localparam int ST_BUSY      = 0;
  localparam int ST_FRAME_ERR = 1;
  localparam int ST_OVERRUN   = 2;
  localparam int ST_VALID     = 3;
  localparam int ST_CNT_LSB   = 4;

endpackage

// File: rtl/tt_micro_sync2.sv
// Width-parameterised two-flop synchroniser for asynchronous inputs.
// Latency: two clk edges from input change to q.
// No backpressure; samples every cycle.
module tt_micro_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two back-to-back flops; the first may go metastable, the second resolves it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/tt_um_micro_descramble_rx.sv
// Serial MSB-first byte receiver that XOR-descrambles each byte and exposes data/status.
// Latency: strobe sampled at edge N for the 8th bit -> byte on uo_out after edge N+3.
// No backpressure: a new byte overwrites an unacknowledged one and flags overrun.
module tt_um_micro_descramble_rx
  import tt_micro_rx_pkg::*;
#(
  parameter logic [7:0] SCRAMBLE_KEY = DEFAULT_SCRAMBLE_KEY
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out
);

  logic [2:0] sync_in;
  logic [2:0] sync_q;
  logic       frame_s;
  logic       strobe_s;
  logic       sdata_s;
  logic       strobe_hist;
  logic       bit_event;

  logic       view;
  logic       ack;
  logic       err_clr;
  logic       unused_bits;

  state_t     state;
  state_t     state_nxt;

  logic       start_bit;
  logic       shift_bit;
  logic       drop;
  logic       abort;
  logic       byte_done;

  logic [7:0] shift_reg;
  logic [7:0] shift_next;
  logic [2:0] bit_cnt;
  logic [3:0] byte_cnt;
  logic [7:0] data_reg;
  logic       valid;
  logic       overrun;
  logic       frame_err;
  logic [7:0] status;

  assign sync_in     = {ui_in[2], ui_in[1], ui_in[0]};
  assign view        = ui_in[3];
  assign ack         = ui_in[4];
  assign err_clr     = ui_in[5];
  assign unused_bits = ^ui_in[7:6];

  tt_micro_sync2 #(.WIDTH(3)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (sync_in),
    .q   (sync_q)
  );

  assign frame_s  = sync_q[2];
  assign strobe_s = sync_q[1];
  assign sdata_s  = sync_q[0];

  // History flop on the synchronised strobe for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) strobe_hist <= 1'b0;
    else     strobe_hist <= strobe_s;
  end

  assign bit_event = strobe_s & ~strobe_hist;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state: framing opens a byte on the first strobe, closes on frame low
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bit_event && frame_s) state_nxt = SHIFT;
      SHIFT:   if (!frame_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: datapath strobes; frame low outranks a coincident bit event
  always_comb begin
    start_bit = 1'b0;
    shift_bit = 1'b0;
    drop      = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: start_bit = bit_event && frame_s;
      SHIFT: begin
        if (!frame_s) begin
          drop  = 1'b1;
          abort = (bit_cnt != 3'd0);
        end else begin
          shift_bit = bit_event;
        end
      end
      default: ;
    endcase
  end

  assign shift_next = {shift_reg[6:0], sdata_s};
  assign byte_done  = shift_bit && (bit_cnt == 3'd7);

  // Shift register and bit counter; bit_cnt wraps 7 -> 0 on byte completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (drop) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (start_bit || shift_bit) begin
      shift_reg <= shift_next;
      bit_cnt   <= bit_cnt + 3'd1;
    end
  end

  // Completed byte capture and wrapping byte counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_reg <= '0;
      byte_cnt <= '0;
    end else if (byte_done) begin
      data_reg <= shift_next ^ SCRAMBLE_KEY;
      byte_cnt <= byte_cnt + 4'd1;
    end
  end

  // Valid/overrun/frame_err flags; a set in the same cycle beats ack or err_clr
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid     <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (byte_done)    valid <= 1'b1;
      else if (ack)     valid <= 1'b0;

      if (byte_done && valid && !ack) overrun <= 1'b1;
      else if (err_clr)               overrun <= 1'b0;

      if (abort)        frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
    end
  end

  always_comb begin
    status                            = '0;
    status[ST_CNT_LSB +: 4]           = byte_cnt;
    status[ST_VALID]                  = valid;
    status[ST_OVERRUN]                = overrun;
    status[ST_FRAME_ERR]              = frame_err;
    status[ST_BUSY]                   = (state == SHIFT);
  end

  // Registered output view
  always_ff @(posedge clk or posedge rst) begin
    if (rst) uo_out <= '0;
    else     uo_out <= view ? status : data_reg;
  end

endmodule

// File: tb/tb_tt_um_micro_descramble_rx.sv
module tb_tt_um_micro_descramble_rx;

  localparam logic [7:0] KEY = 8'h55;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sdata = 1'b0, sstrobe = 1'b0, frame = 1'b0, view = 1'b0;
  logic       ack = 1'b0, err_clr = 1'b0;
  logic [1:0] junk = 2'b00;
  logic [7:0] ui_in;
  logic [7:0] uo_out;

  int errors = 0;
  int checks = 0;

  // behavioural expectation of the receiver's visible state
  logic [7:0] m_data;
  logic       m_valid, m_over, m_ferr, m_busy;
  int         m_cnt;

  assign ui_in = {junk, err_clr, ack, view, frame, sstrobe, sdata};

  tt_um_micro_descramble_rx #(.SCRAMBLE_KEY(KEY)) dut (
    .clk    (clk),
    .rst    (rst),
    .ui_in  (ui_in),
    .uo_out (uo_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] exp_status();
    logic [3:0] c;
    c = m_cnt[3:0];
    return {c, m_valid, m_over, m_ferr, m_busy};
  endfunction

  task automatic model_reset();
    m_data = 8'h00; m_valid = 0; m_over = 0; m_ferr = 0; m_busy = 0; m_cnt = 0;
  endtask

  task automatic model_byte(input logic [7:0] d, input bit ack_same);
    if (m_valid && !ack_same) m_over = 1;
    m_valid = 1;
    m_data  = d;
    m_cnt   = (m_cnt + 1) % 16;
    m_busy  = 1;
  endtask

  task automatic send_bit(input logic b, input bit ack_ev);
    @(negedge clk);
    sdata = b; sstrobe = 0; junk = 2'($urandom);
    @(negedge clk);
    @(negedge clk);
    sstrobe = 1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    if (ack_ev) ack = 1;
    @(posedge clk);
    @(negedge clk);
    ack = 0; sstrobe = 0;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input bit ack_last);
    logic [7:0] w;
    w = d ^ KEY;
    for (int i = 7; i >= 0; i--) send_bit(w[i], ack_last && (i == 0));
    model_byte(d, ack_last);
  endtask

  task automatic read_view(input logic v, output logic [7:0] r);
    @(negedge clk);
    view = v;
    @(posedge clk);
    @(posedge clk);
    #1 r = uo_out;
  endtask

  task automatic pulse_ack();
    @(negedge clk); ack = 1;
    @(negedge clk); ack = 0;
    m_valid = 0;
  endtask

  task automatic pulse_err_clr();
    @(negedge clk); err_clr = 1;
    @(negedge clk); err_clr = 0;
    m_over = 0; m_ferr = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1;
    @(negedge clk); @(negedge clk); rst = 0;
    model_reset();
    repeat (3) @(negedge clk);
  endtask

  task automatic check_both(input string tag);
    logic [7:0] r;
    read_view(0, r);
    checks++;
    if (r !== m_data) begin
      errors++; $display("FAIL %s data: got %h expected %h", tag, r, m_data);
    end
    read_view(1, r);
    checks++;
    if (r !== exp_status()) begin
      errors++; $display("FAIL %s status: got %b expected %b", tag, r, exp_status());
    end
    @(negedge clk); view = 0;
  endtask

  task automatic test_reset();
    logic [7:0] r;
    model_reset();
    #3;
    checks++;
    if (uo_out !== 8'h00) begin
      errors++; $display("FAIL reset_async uo_out: got %h expected 00", uo_out);
    end
    repeat (3) @(negedge clk);
    rst = 0;
    read_view(1, r);
    checks++;
    if (r !== 8'h00) begin
      errors++; $display("FAIL reset status: got %b expected 00000000", r);
    end
    read_view(0, r);
    checks++;
    if (r !== 8'h00) begin
      errors++; $display("FAIL reset data: got %h expected 00", r);
    end
  endtask

  task automatic test_latency();
    logic [7:0] w;
    logic [7:0] r;
    frame = 1;
    repeat (4) @(negedge clk);
    w = 8'h55 ^ KEY;
    for (int i = 7; i >= 1; i--) send_bit(w[i], 0);
    @(negedge clk); sdata = w[0]; sstrobe = 0;
    @(negedge clk); @(negedge clk);
    sstrobe = 1;
    @(posedge clk);               // edge N
    @(posedge clk);               // N+1
    @(posedge clk); #1;           // N+2
    checks++;
    if (uo_out !== 8'h00) begin
      errors++; $display("FAIL latency_early: got %h expected 00 at N+2", uo_out);
    end
    @(posedge clk); #1;           // N+3
    checks++;
    if (uo_out !== 8'h55) begin
      errors++; $display("FAIL latency_n3: got %h expected 55 at N+3", uo_out);
    end
    @(negedge clk); sstrobe = 0;
    model_byte(8'h55, 0);
    read_view(1, r);
    checks++;
    if (r !== 8'b0001_1001) begin
      errors++; $display("FAIL first_status: got %b expected 00011001", r);
    end
    @(negedge clk); view = 0;
  endtask

  task automatic test_overrun();
    logic [7:0] r;
    pulse_ack();
    send_byte(8'hA5, 0);
    send_byte(8'h3C, 0);
    check_both("overrun");
    read_view(1, r);
    checks++;
    if (r[2] !== 1'b1) begin
      errors++; $display("FAIL overrun_flag: got %b expected 1", r[2]);
    end
    pulse_err_clr();
    read_view(1, r);
    checks++;
    if (r[3:2] !== 2'b10) begin
      errors++; $display("FAIL err_clr valid/overrun: got %b expected 10", r[3:2]);
    end
    @(negedge clk); view = 0;
  endtask

  task automatic test_frame_drop();
    logic [7:0] w;
    logic [7:0] r;
    w = 8'hE7 ^ KEY;
    for (int i = 7; i >= 3; i--) send_bit(w[i], 0);
    @(negedge clk); frame = 0;
    repeat (4) @(negedge clk);
    m_busy = 0; m_ferr = 1;
    check_both("frame_drop");
    read_view(1, r);
    checks++;
    if (r[1:0] !== 2'b10) begin
      errors++; $display("FAIL frame_drop ferr/busy: got %b expected 10", r[1:0]);
    end
    @(negedge clk); view = 0; frame = 1;
    repeat (4) @(negedge clk);
    send_byte(8'hC3, 0);
    check_both("after_drop");
  endtask

  task automatic test_ack_same_cycle();
    logic [7:0] r;
    pulse_err_clr();
    send_byte(8'h7E, 1);
    check_both("ack_same");
    read_view(1, r);
    checks++;
    if (r[3:2] !== 2'b10) begin
      errors++; $display("FAIL ack_same valid/overrun: got %b expected 10", r[3:2]);
    end
    @(negedge clk); view = 0;
  endtask

  task automatic test_wrap();
    logic [7:0] r;
    do_reset();
    for (int k = 0; k < 17; k++) send_byte(8'(k * 13 + 7), 0);
    read_view(1, r);
    checks++;
    if (r[7:4] !== 4'd1) begin
      errors++; $display("FAIL wrap byte_cnt: got %0d expected 1", r[7:4]);
    end
    check_both("wrap");
  endtask

  task automatic test_random();
    logic [7:0] d;
    for (int k = 0; k < 6; k++) begin
      if ($urandom_range(1, 0) == 1) pulse_ack();
      if ($urandom_range(2, 0) == 0) pulse_err_clr();
      d = 8'($urandom);
      send_byte(d, 0);
      check_both("random");
    end
  endtask

  task automatic test_reset_midbyte();
    logic [7:0] r;
    logic [7:0] w;
    read_view(1, r);
    w = 8'hF0;
    for (int i = 7; i >= 5; i--) send_bit(w[i], 0);
    m_busy = 1;
    #1;
    checks++;
    if (uo_out !== exp_status()) begin
      errors++; $display("FAIL midbyte_pre status: got %b expected %b", uo_out, exp_status());
    end
    @(negedge clk);
    #2 rst = 1;
    #1;
    checks++;
    if (uo_out !== 8'h00) begin
      errors++; $display("FAIL reset_midbyte async: got %h expected 00", uo_out);
    end
    @(negedge clk); @(negedge clk); rst = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_both("post_reset");
    send_byte(8'h5A, 0);
    check_both("clean_byte");
    read_view(1, r);
    checks++;
    if (r !== 8'b0001_1001) begin
      errors++; $display("FAIL clean_byte status: got %b expected 00011001", r);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_overrun();
    test_frame_drop();
    test_ack_same_cycle();
    test_wrap();
    test_random();
    test_reset_midbyte();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
